alu_exec_unit: RTL and testbench

Registered execute-stage datapath slice for the single-cycle MIPS-style processor. It decodes the ALU operation from the main-control ALUOp bits and the R-type funct field, and performs the 32-bit ALU operation with zero/negative/jump flags. It also computes the PC+4 and branch-target adders. All results are captured in output registers, one cycle after the operands are presented.

---
 rtl/alu_exec_unit.sv | 121 ++++++++++++
 tb/tb_alu_exec_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Registered MIPS-style execute slice: ALU control decode, 32-bit
//            ALU with zero/negative/jump flags, PC+4 and branch-target adders.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  aluop,
   input  logic [5:0]  funct,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   input  logic [31:0] pc,
   input  logic [31:0] offset,
   output logic [31:0] result,
   output logic        zero,
   output logic        negative,
   output logic        jmor,
   output logic [2:0]  gout,
   output logic [31:0] pc_plus4,
   output logic [31:0] branch_target
);

   localparam logic [2:0] c_alu_and  = 3'b000;
   localparam logic [2:0] c_alu_or   = 3'b001;
   localparam logic [2:0] c_alu_add  = 3'b010;
   localparam logic [2:0] c_alu_sll  = 3'b011;
   localparam logic [2:0] c_alu_pass = 3'b100;
   localparam logic [2:0] c_alu_xor  = 3'b101;
   localparam logic [2:0] c_alu_sub  = 3'b110;
   localparam logic [2:0] c_alu_slt  = 3'b111;

   logic [2:0]  w_gout;
   logic [31:0] w_result;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_branch_target;

   logic [31:0] r_result;
   logic        r_zero;
   logic        r_negative;
   logic        r_jmor;
   logic [2:0]  r_gout;
   logic [31:0] r_pc_plus4;
   logic [31:0] r_branch_target;

   always_comb begin
      w_gout = c_alu_add;
      case (aluop)
         3'b000: w_gout = c_alu_add;
         3'b001: w_gout = c_alu_sub;
         3'b011: w_gout = c_alu_and;
         3'b100: w_gout = c_alu_or;
         3'b010: begin
            case (funct)
               6'b100000: w_gout = c_alu_add;
               6'b100010: w_gout = c_alu_sub;
               6'b100100: w_gout = c_alu_and;
               6'b100101: w_gout = c_alu_or;
               6'b101010: w_gout = c_alu_slt;
               6'b000000: w_gout = c_alu_sll;
               6'b001000,
               6'b010111: w_gout = c_alu_pass;
               default:   w_gout = c_alu_add;
            endcase
         end
         default: w_gout = c_alu_add;
      endcase
   end

   always_comb begin
      w_result = 32'h0;
      case (w_gout)
         c_alu_and:  w_result = a & b;
         c_alu_or:   w_result = a | b;
         c_alu_add:  w_result = a + b;
         c_alu_sll:  w_result = b << shamt;
         c_alu_pass: w_result = a;
         c_alu_xor:  w_result = a ^ b;
         c_alu_sub:  w_result = a - b;
         c_alu_slt:  w_result = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
         default:    w_result = 32'h0;
      endcase
   end

   // Branch target is built from the PC+4 sum so both adders share one chain.
   assign w_pc_plus4      = pc + 32'h4;
   assign w_branch_target = w_pc_plus4 + {offset[29:0], 2'b00};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_result        <= 32'h0;
         r_zero          <= 1'b0;
         r_negative      <= 1'b0;
         r_jmor          <= 1'b0;
         r_gout          <= 3'b000;
         r_pc_plus4      <= 32'h0;
         r_branch_target <= 32'h0;
      end else begin
         r_result        <= w_result;
         r_zero          <= (w_result == 32'h0);
         r_negative      <= w_result[31];
         r_jmor          <= (w_gout == c_alu_pass);
         r_gout          <= w_gout;
         r_pc_plus4      <= w_pc_plus4;
         r_branch_target <= w_branch_target;
      end
   end

   assign result        = r_result;
   assign zero          = r_zero;
   assign negative      = r_negative;
   assign jmor          = r_jmor;
   assign gout          = r_gout;
   assign pc_plus4      = r_pc_plus4;
   assign branch_target = r_branch_target;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Self-checking bench for alu_exec_unit against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

   typedef struct packed {
      logic [2:0]  aluop;
      logic [5:0]  funct;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  shamt;
   } stim_t;

   typedef struct packed {
      logic [31:0] result;
      logic        zero;
      logic        negative;
      logic        jmor;
      logic [2:0]  gout;
      logic [31:0] pc_plus4;
      logic [31:0] branch_target;
   } out_t;

   localparam longint unsigned c_mod = 64'h1_0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  aluop = '0;
   logic [5:0]  funct = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [4:0]  shamt = '0;
   logic [31:0] pc = '0;
   logic [31:0] offset = '0;
   logic [31:0] result;
   logic        zero;
   logic        negative;
   logic        jmor;
   logic [2:0]  gout;
   logic [31:0] pc_plus4;
   logic [31:0] branch_target;

   int   n_cmp = 0;
   int   n_fail = 0;
   out_t exp_o;
   out_t obs_o;

   alu_exec_unit dut (
      .clk(clk), .reset(reset), .aluop(aluop), .funct(funct), .a(a), .b(b),
      .shamt(shamt), .pc(pc), .offset(offset), .result(result), .zero(zero),
      .negative(negative), .jmor(jmor), .gout(gout), .pc_plus4(pc_plus4),
      .branch_target(branch_target)
   );

   always #5 clk = ~clk;

   function automatic out_t observed();
      return '{result, zero, negative, jmor, gout, pc_plus4, branch_target};
   endfunction

   // Reference: pick the operation from the decode table, then evaluate it
   // with wide unsigned/signed integer arithmetic reduced modulo 2^32.
   function automatic out_t model(stim_t s, logic [31:0] pcv, logic [31:0] offv);
      logic [2:0]      g;
      longint unsigned ua, ub, r, upc, uoff;
      longint          sa, sb;
      out_t            o;
      ua = s.a; ub = s.b; upc = pcv; uoff = offv;
      if (s.aluop == 3'b010) begin
         case (s.funct)
            6'b100010: g = 3'd6;
            6'b100100: g = 3'd0;
            6'b100101: g = 3'd1;
            6'b101010: g = 3'd7;
            6'b000000: g = 3'd3;
            6'b001000: g = 3'd4;
            6'b010111: g = 3'd4;
            default:   g = 3'd2;
         endcase
      end else if (s.aluop == 3'b001) g = 3'd6;
      else if (s.aluop == 3'b011)     g = 3'd0;
      else if (s.aluop == 3'b100)     g = 3'd1;
      else                            g = 3'd2;
      sa = (ua >= c_mod / 2) ? longint'(ua) - longint'(c_mod) : longint'(ua);
      sb = (ub >= c_mod / 2) ? longint'(ub) - longint'(c_mod) : longint'(ub);
      case (g)
         3'd0:    r = ua & ub;
         3'd1:    r = ua | ub;
         3'd2:    r = (ua + ub) % c_mod;
         3'd3:    r = (ub * (64'd1 << s.shamt)) % c_mod;
         3'd4:    r = ua;
         3'd5:    r = ua ^ ub;
         3'd6:    r = (ua + c_mod - ub) % c_mod;
         default: r = (sa < sb) ? 64'd1 : 64'd0;
      endcase
      o.result        = r[31:0];
      o.zero          = (r == 0);
      o.negative      = (r >= c_mod / 2);
      o.jmor          = (g == 3'd4);
      o.gout          = g;
      o.pc_plus4      = 32'((upc + 4) % c_mod);
      o.branch_target = 32'((upc + 4 + uoff * 4) % c_mod);
      return o;
   endfunction

   task automatic step(input stim_t s, input logic [31:0] pcv, input logic [31:0] offv);
      @(negedge clk);
      aluop = s.aluop; funct = s.funct; a = s.a; b = s.b; shamt = s.shamt;
      pc = pcv; offset = offv;
      exp_o = model(s, pcv, offv);
      @(posedge clk);
      #1;
      obs_o = observed();
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (observed() !== out_t'(0)) begin
         n_fail++; $display("FAIL reset_initial: got %h want 0", observed());
      end
      @(negedge clk) reset = 1'b0;
      step('{3'b000, 6'd0, 32'h1234, 32'h1, 5'd0}, 32'h100, 32'h8);
      n_cmp++;
      if (obs_o !== exp_o) begin
         n_fail++; $display("FAIL reset_preload: got %h want %h", obs_o, exp_o);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (observed() !== out_t'(0)) begin
         n_fail++; $display("FAIL reset_async: got %h want 0", observed());
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (observed() !== out_t'(0)) begin
         n_fail++; $display("FAIL reset_held: got %h want 0", observed());
      end
      @(negedge clk) reset = 1'b0;
      step('{3'b000, 6'd0, 32'd5, 32'd7, 5'd0}, 32'h0, 32'h0);
      n_cmp++;
      if (result !== 32'd12 || gout !== 3'b010 || zero !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got result=%h gout=%b zero=%b want 0000000c 010 0", result, gout, zero);
      end
   endtask

   task automatic run_rows(input string name, input stim_t rows[8], input logic [31:0] want[8],
                           input logic [31:0] pcs[8], input logic [31:0] offs[8], input int n);
      for (int i = 0; i < n; i++) begin
         step(rows[i], pcs[i], offs[i]);
         n_cmp++;
         if (obs_o !== exp_o) begin
            n_fail++; $display("FAIL %s[%0d] model: got %h want %h", name, i, obs_o, exp_o);
         end
         n_cmp++;
         if (result !== want[i]) begin
            n_fail++; $display("FAIL %s[%0d] result: got %h want %h", name, i, result, want[i]);
         end
      end
   endtask

   task automatic test_rtype();
      stim_t       rows[8];
      logic [31:0] want[8];
      logic [31:0] z[8];
      z = '{default: 32'h0};
      rows = '{'{3'b010, 6'b100100, 32'hC, 32'hA, 5'd0},
               '{3'b010, 6'b100101, 32'hC, 32'hA, 5'd0},
               '{3'b010, 6'b100010, 32'hC, 32'hA, 5'd0},
               '{3'b010, 6'b101010, 32'hFFFFFFFF, 32'h1, 5'd0},
               '{3'b010, 6'b111111, 32'hC, 32'hA, 5'd0},
               '{3'b010, 6'b000000, 32'hDEAD, 32'h3, 5'd4},
               '{3'b010, 6'b001000, 32'h40, 32'h99, 5'd0},
               '{3'b010, 6'b010111, 32'h80000000, 32'h5, 5'd0}};
      want = '{32'h8, 32'hE, 32'h2, 32'h1, 32'h16, 32'h30, 32'h40, 32'h80000000};
      run_rows("rtype", rows, want, z, z, 8);
      n_cmp++;
      if (jmor !== 1'b1 || gout !== 3'b100) begin
         n_fail++; $display("FAIL balrn_jmor: got jmor=%b gout=%b want 1 100", jmor, gout);
      end
   endtask

   task automatic test_flags_wrap_adders();
      stim_t       rows[8];
      logic [31:0] want[8];
      logic [31:0] pcs[8];
      logic [31:0] offs[8];
      rows = '{'{3'b001, 6'd0, 32'h1234, 32'h1234, 5'd0},
               '{3'b001, 6'd0, 32'h0, 32'h1, 5'd0},
               '{3'b000, 6'd0, 32'hFFFFFFFF, 32'h2, 5'd0},
               '{3'b011, 6'd0, 32'h00FF00FF, 32'hFFFF0F0F, 5'd0},
               '{3'b100, 6'd0, 32'hF0, 32'h0F, 5'd0},
               '{3'b111, 6'd0, 32'h3, 32'h4, 5'd0},
               '{3'b000, 6'd0, 32'h1, 32'h1, 5'd0},
               '{3'b000, 6'd0, 32'h1, 32'h1, 5'd0}};
      want = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h00FF000F, 32'hFF, 32'h7, 32'h2, 32'h2};
      pcs  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h10, 32'hFFFFFFFC};
      offs = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h0};
      step(rows[0], 32'h0, 32'h0);
      n_cmp++;
      if (result !== 32'h0 || zero !== 1'b1 || negative !== 1'b0) begin
         n_fail++; $display("FAIL flag_zero: got %h z=%b n=%b want 0 1 0", result, zero, negative);
      end
      step(rows[1], 32'h0, 32'h0);
      n_cmp++;
      if (negative !== 1'b1 || zero !== 1'b0) begin
         n_fail++; $display("FAIL flag_neg: got z=%b n=%b want 0 1", zero, negative);
      end
      run_rows("wrap", rows, want, pcs, offs, 8);
      step(rows[6], 32'h10, 32'hFFFFFFFE);
      n_cmp++;
      if (pc_plus4 !== 32'h14 || branch_target !== 32'h0C) begin
         n_fail++; $display("FAIL adders: got %h %h want 00000014 0000000c", pc_plus4, branch_target);
      end
      step(rows[7], 32'hFFFFFFFC, 32'h0);
      n_cmp++;
      if (pc_plus4 !== 32'h0) begin
         n_fail++; $display("FAIL pc_wrap: got %h want 0", pc_plus4);
      end
   endtask

   task automatic test_hold();
      out_t  held;
      stim_t s;
      step('{3'b010, 6'b100000, 32'h11, 32'h22, 5'd0}, 32'h40, 32'h3);
      held = exp_o;
      #2;
      s = '{3'b001, 6'd0, $urandom, $urandom, 5'($urandom)};
      aluop = s.aluop; a = s.a; b = s.b; shamt = s.shamt; pc = 32'h80; offset = 32'h7;
      #1;
      n_cmp++;
      if (observed() !== held) begin
         n_fail++; $display("FAIL hold_between_edges: got %h want %h", observed(), held);
      end
      @(posedge clk);
      #1;
      exp_o = model(s, 32'h80, 32'h7);
      n_cmp++;
      if (observed() !== exp_o) begin
         n_fail++; $display("FAIL hold_next_edge: got %h want %h", observed(), exp_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0]  fl[9];
      logic [31:0] edge_v[4];
      stim_t       s;
      fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
             6'b000000, 6'b001000, 6'b010111, 6'b111111};
      edge_v = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
      for (int i = 0; i < 400; i++) begin
         s.aluop = 3'($urandom_range(0, 7));
         s.funct = ($urandom_range(0, 1) == 0) ? fl[$urandom_range(0, 8)] : 6'($urandom);
         s.a     = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
         s.b     = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
         if ($urandom_range(0, 7) == 0) s.b = s.a;
         s.shamt = 5'($urandom);
         step(s, $urandom, $urandom);
         n_cmp++;
         if (obs_o !== exp_o) begin
            n_fail++; $display("FAIL random[%0d]: got %h want %h", i, obs_o, exp_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_flags_wrap_adders();
      test_hold();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
